req_capture_arbiter: RTL and testbench
======================================

// Module: req_capture_arbiter
// PURPOSE
//  Upstream stage of the 8-to-3 encoder. Captures rising edges on 8 asynchronous request
//  lines into a pending register and presents exactly one pending request at a time as an
//  8-bit one-hot vector with a valid/ready handshake. The encoder consumes grant_onehot and
//  turns it into a 3-bit code. The block never drives more than one hot bit, and holds
//  grant_onehot at 8'h00 when idle.
// PARAMETERS
//  SYNC_STAGES  2  flops per request line in the synchronizer (legal: 2..4)
//  ROUND_ROBIN  0  0 = fixed priority (bit 7 highest); 1 = rotating priority
// PORTS
//  clk           in   1  single clock; all logic on the rising edge
//  rst           in   1  synchronous reset, active-high
//  req_in        in   8  asynchronous request lines, level; a rising edge = one event
//  req_mask      in   8  1 = line eligible for grant; masked bits stay pending, never granted
//  grant_ready   in   1  consumer accepts grant this cycle
//  grant_valid   out  1  grant_onehot holds a valid request
//  grant_onehot  out  8  one-hot selected request; 8'h00 whenever grant_valid=0
//  pending       out  8  captured, not-yet-accepted requests (includes the presented one)
//  overflow      out  1  sticky: an edge arrived on a line already pending
//  ovf_clr       in   1  clears overflow (set wins over clear in the same cycle)
// BEHAVIOUR
//  Reset: sync chain, edge-history flops, pending, grant_valid, grant_onehot, overflow = 0.
//   Round-robin pointer = 7. A line held high across reset release counts as one edge.
//  Sync/edge: each line passes SYNC_STAGES flops, then rise[i] = s[i] & ~prev[i].
//  Pending: on accept (grant_valid & grant_ready) the presented bit is cleared. rise[i]
//   sets pending[i]. If set and clear hit the same bit in one cycle, set wins: the bit
//   stays pending as a new event.
//  Overflow: rise[i] while pending[i]=1 and bit i is not being accepted this cycle
//   -> overflow<=1. The event is lost (no counter).
//  Latency: line rising before edge 1 -> pending at edge SYNC_STAGES+1 -> grant_valid at
//   edge SYNC_STAGES+2 (edge 4 for default), provided the output register is free.
//  Output register: loads when (!grant_valid | grant_ready). The candidate set is
//   pending & req_mask & ~accepted_bit. Pending bits set on the same edge are not
//   included; they are seen next cycle. An empty candidate set loads valid=0, onehot=0.
//  Handshake: while grant_valid=1 & grant_ready=0, grant_onehot is held stable.
//   Mask and pending changes do not alter it. Back-to-back accepts give one grant per
//   cycle.
//  Fixed priority: pick the highest set index.
//  Round-robin: start at ptr and search downward, wrapping 0->7. On accept of bit i,
//   ptr <= (i-1) mod 8 (i=0 wraps to 7). The pointer moves only on accept.
//  States (grant side): IDLE (valid=0) -> PRESENT when the candidate set is non-empty.
//   PRESENT -> PRESENT on accept with more candidates; PRESENT -> IDLE on accept with
//   none. PRESENT holds otherwise.
//  Mid-operation rst: all state cleared next edge; an unaccepted grant is dropped.
//  grant_ready while grant_valid=0 is ignored.
// TESTING
//  T1 reset: rst=1 for 2 cycles, req_in=8'hFF -> all outputs 0. Release -> pending=8'hFF
//   at edge 3, grant_onehot=8'h80 at edge 4.
//  T2 fixed priority: pulse req_in bits 2,5 together, grant_ready=1 -> grants 8'h20 then
//   8'h04 on consecutive cycles, then valid=0 and pending=0.
//  T3 stall: grant 8'h10 presented, grant_ready=0 for 5 cycles, raise req bit 7 -> onehot
//   stays 8'h10. Accept -> next grant is 8'h80.
//  T4 overflow/mask: req_mask=8'hFE, pulse bit 0 twice -> pending[0]=1, never granted,
//   overflow=1. ovf_clr -> overflow=0. Unmask -> grant 8'h01.
//  T5 round-robin (ROUND_ROBIN=1): hold bits 7 and 6 re-pulsing after each accept ->
//   grants alternate 8'h80, 8'h40, 8'h80 ...
//  T6 set/clear collision: new edge on bit 3 in the same cycle its grant is accepted ->
//   pending[3] stays 1, overflow=0, and 8'h08 is granted again.

Source files
------------

// File: rtl/req_capture_arbiter.sv
// req_capture_arbiter: front end of the 8-to-3 encoder.
// Synchronizes eight asynchronous request lines and turns each rising edge into a
// pending bit. One pending, unmasked request at a time is offered as a one-hot grant.
// Handshake: the grant is transferred on a cycle where grant_valid and grant_ready
// are both 1. While grant_valid=1 and grant_ready=0, grant_onehot is frozen. When
// grant_valid=0, grant_onehot is 8'h00 and grant_ready is ignored.
// SYNC_STAGES must lie in 2..4.
module req_capture_arbiter #(
  parameter int SYNC_STAGES = 2,
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req_in,
  input  logic [7:0] req_mask,
  input  logic       grant_ready,
  output logic       grant_valid,
  output logic [7:0] grant_onehot,
  output logic [7:0] pending,
  output logic       overflow,
  input  logic       ovf_clr
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     state;
  logic [7:0] sync_q [SYNC_STAGES];
  logic [7:0] prev_q;
  logic [7:0] rise;
  logic [7:0] accepted;
  logic [7:0] cand;
  logic [7:0] pick;
  logic [2:0] rr_ptr;
  logic [2:0] start_idx;
  logic [2:0] sel_idx;
  logic       accept;

  // The state register doubles as the valid flag so the two can never disagree.
  assign grant_valid = (state == PRESENT);

  // Synchronizer chain; stage 0 samples the raw asynchronous lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= req_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Edge history. Clearing it on reset makes a line held high across reset count once.
  always_ff @(posedge clk) begin
    if (rst) prev_q <= '0;
    else     prev_q <= sync_q[SYNC_STAGES-1];
  end

  assign rise     = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign accept   = grant_valid & grant_ready;
  assign accepted = accept ? grant_onehot : 8'h00;
  // Bits set on this edge are excluded here; they become candidates next cycle.
  assign cand     = pending & req_mask & ~accepted;

  // Priority search: walk downward from the start index, wrapping 0 -> 7.
  // A start of 7 makes this plain highest-index-first fixed priority.
  assign start_idx = ROUND_ROBIN ? rr_ptr : 3'd7;

  // Select the first candidate found on the downward walk.
  always_comb begin
    logic       found;
    logic [2:0] idx;
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < 8; k++) begin
      idx = start_idx - 3'(k);
      if (!found && cand[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  // Index of the presented bit, used to advance the round-robin pointer.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (grant_onehot[i]) sel_idx = 3'(i);
    end
  end

  // Pending set/clear: a new edge wins over the clear of an accepted bit.
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~accepted) | rise;
  end

  // Sticky overflow: an edge on a line that is already pending and not leaving now.
  always_ff @(posedge clk) begin
    if (rst)                                overflow <= 1'b0;
    else if (|(rise & pending & ~accepted)) overflow <= 1'b1;
    else if (ovf_clr)                       overflow <= 1'b0;
  end

  // Round-robin pointer: after granting bit i, the search next starts at i-1.
  always_ff @(posedge clk) begin
    if (rst)         rr_ptr <= 3'd7;
    else if (accept) rr_ptr <= sel_idx - 3'd1;
  end

  // Grant FSM: the output register reloads when empty or when the grant is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      grant_onehot <= '0;
    end else if ((state == IDLE) || grant_ready) begin
      if (|pick) begin
        state        <= PRESENT;
        grant_onehot <= pick;
      end else begin
        state        <= IDLE;
        grant_onehot <= '0;
      end
    end
  end

endmodule

// File: tb/tb_req_capture_arbiter.sv
// Bench for req_capture_arbiter: a fixed-priority and a round-robin instance share
// the same stimulus; each is compared every cycle against its own reference model.
module tb_req_capture_arbiter;

  localparam int SYNC = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [7:0] req_in = '0;
  logic [7:0] req_mask = 8'hFF;
  logic       grant_ready = 1'b0;
  logic       ovf_clr = 1'b0;

  logic       fp_valid, rr_valid;
  logic [7:0] fp_onehot, rr_onehot;
  logic [7:0] fp_pending, rr_pending;
  logic       fp_overflow, rr_overflow;

  req_capture_arbiter #(.SYNC_STAGES(SYNC), .ROUND_ROBIN(1'b0)) dut_fp (
    .clk(clk), .rst(rst), .req_in(req_in), .req_mask(req_mask),
    .grant_ready(grant_ready), .grant_valid(fp_valid), .grant_onehot(fp_onehot),
    .pending(fp_pending), .overflow(fp_overflow), .ovf_clr(ovf_clr));

  req_capture_arbiter #(.SYNC_STAGES(SYNC), .ROUND_ROBIN(1'b1)) dut_rr (
    .clk(clk), .rst(rst), .req_in(req_in), .req_mask(req_mask),
    .grant_ready(grant_ready), .grant_valid(rr_valid), .grant_onehot(rr_onehot),
    .pending(rr_pending), .overflow(rr_overflow), .ovf_clr(ovf_clr));

  // ---------------- scoreboard ----------------
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Synchronizer as a delay queue: exp_q[0] is what the last stage holds.
  logic [7:0] exp_q[$];
  logic [7:0] m_prev;
  logic       m_valid [2];
  logic [7:0] m_hot   [2];
  logic [7:0] m_pend  [2];
  logic       m_ovf   [2];
  int         m_ptr   [2];

  function automatic int idx_of(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Fixed: highest index. Round-robin: smallest downward distance from ptr.
  function automatic logic [7:0] choose(input logic [7:0] cand, input int rr, input int ptr);
    logic [7:0] r;
    int best, best_d, d;
    r = '0;
    best = -1;
    best_d = 99;
    for (int i = 0; i < 8; i++) begin
      if (cand[i]) begin
        d = rr ? (ptr - i + 8) % 8 : 7 - i;
        if (d < best_d) begin
          best_d = d;
          best = i;
        end
      end
    end
    if (best >= 0) r[best] = 1'b1;
    return r;
  endfunction

  task automatic model_edge();
    logic [7:0] rise, acc, nh;
    bit took;
    if (rst) begin
      exp_q.delete();
      for (int k = 0; k < SYNC; k++) exp_q.push_back(8'h00);
      m_prev = '0;
      for (int d = 0; d < 2; d++) begin
        m_valid[d] = 1'b0; m_hot[d] = '0; m_pend[d] = '0; m_ovf[d] = 1'b0; m_ptr[d] = 7;
      end
    end else begin
      rise = exp_q[0] & ~m_prev;
      for (int d = 0; d < 2; d++) begin
        took = m_valid[d] && grant_ready;
        acc  = took ? m_hot[d] : 8'h00;
        if (!m_valid[d] || grant_ready) begin
          nh = choose(m_pend[d] & req_mask & ~acc, d, m_ptr[d]);
          if (took) m_ptr[d] = (idx_of(m_hot[d]) + 7) % 8;
          m_hot[d]   = nh;
          m_valid[d] = (nh != 8'h00);
        end
        if ((rise & m_pend[d] & ~acc) != 8'h00) m_ovf[d] = 1'b1;
        else if (ovf_clr)                       m_ovf[d] = 1'b0;
        m_pend[d] = (m_pend[d] & ~acc) | rise;
      end
      m_prev = exp_q[0];
      void'(exp_q.pop_front());
      exp_q.push_back(req_in);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("fp_valid",   32'(fp_valid),    32'(m_valid[0]));
    check("fp_onehot",  32'(fp_onehot),   32'(m_hot[0]));
    check("fp_pending", 32'(fp_pending),  32'(m_pend[0]));
    check("fp_ovf",     32'(fp_overflow), 32'(m_ovf[0]));
    check("rr_valid",   32'(rr_valid),    32'(m_valid[1]));
    check("rr_onehot",  32'(rr_onehot),   32'(m_hot[1]));
    check("rr_pending", 32'(rr_pending),  32'(m_pend[1]));
    check("rr_ovf",     32'(rr_overflow), 32'(m_ovf[1]));
  endtask

  task automatic wait_fp_valid(input string tag, input int budget);
    int n = 0;
    while (!fp_valid && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(fp_valid), 32'd1);
  endtask

  task automatic drain();
    req_in = '0;
    req_mask = 8'hFF;
    grant_ready = 1'b1;
    repeat (14) step();
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] rr_seq[$];

  initial begin
    // T1: reset with all lines high, then release
    rst = 1'b1; req_in = 8'hFF; grant_ready = 1'b0;
    step(); step();
    check("t1_rst_pending", 32'(fp_pending), 32'h0);
    check("t1_rst_valid",   32'(fp_valid),   32'h0);
    rst = 1'b0;
    step(); step(); step();
    check("t1_pend_edge3", 32'(fp_pending), 32'hFF);
    step();
    check("t1_grant_edge4", 32'(fp_onehot), 32'h80);
    drain();

    // T2: fixed priority, bits 5 and 2 together
    req_in = 8'h24; step(); req_in = 8'h00;
    wait_fp_valid("t2_wait", 10);
    check("t2_first", 32'(fp_onehot), 32'h20);
    step();
    check("t2_second", 32'(fp_onehot), 32'h04);
    step();
    check("t2_idle_valid", 32'(fp_valid), 32'h0);
    check("t2_idle_pend",  32'(fp_pending), 32'h0);
    drain();

    // T3: stall holds the grant while a higher request arrives
    grant_ready = 1'b0;
    req_in = 8'h10; step(); req_in = 8'h00;
    wait_fp_valid("t3_wait", 10);
    req_in = 8'h80;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_hold", 32'(fp_onehot), 32'h10);
    end
    grant_ready = 1'b1;
    step();
    check("t3_next", 32'(fp_onehot), 32'h80);
    drain();

    // T6: new edge on bit 3 in the cycle its grant is accepted
    grant_ready = 1'b0;
    req_in = 8'h08; step(); req_in = 8'h00;
    wait_fp_valid("t6_wait", 10);
    check("t6_first", 32'(fp_onehot), 32'h08);
    req_in = 8'h08;
    repeat (SYNC) step();
    grant_ready = 1'b1;
    step();
    check("t6_pend3", 32'(fp_pending[3]), 32'h1);
    check("t6_ovf",   32'(fp_overflow),   32'h0);
    step();
    check("t6_regrant", 32'(fp_onehot), 32'h08);
    drain();

    // T4: masked line accumulates an overflow, clear, then unmask
    req_mask = 8'hFE;
    req_in = 8'h01; step(); req_in = 8'h00; step(); step();
    req_in = 8'h01; step(); req_in = 8'h00;
    repeat (6) step();
    check("t4_pend0",  32'(fp_pending[0]), 32'h1);
    check("t4_novalid", 32'(fp_valid),     32'h0);
    check("t4_ovf",    32'(fp_overflow),   32'h1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    check("t4_ovf_clr", 32'(fp_overflow), 32'h0);
    req_mask = 8'hFF; grant_ready = 1'b0;
    step();
    check("t4_unmask", 32'(fp_onehot), 32'h01);
    drain();

    // T5: round-robin alternation between bits 7 and 6
    rst = 1'b1; step(); rst = 1'b0;
    grant_ready = 1'b1;
    for (int p = 0; p < 4; p++) begin
      req_in = 8'hC0; step(); req_in = 8'h00;
      for (int c = 0; c < 6; c++) begin
        if (rr_valid) rr_seq.push_back(rr_onehot);
        step();
      end
    end
    check("t5_count", 32'(rr_seq.size()), 32'd8);
    foreach (rr_seq[i]) check("t5_alt", 32'(rr_seq[i]), (i % 2 == 0) ? 32'h80 : 32'h40);
    drain();

    // Random phase: sparse edges, random mask/ready/clear, occasional reset
    for (int n = 0; n < 1500; n++) begin
      req_in      = req_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 19) == 0)
        req_mask  = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      grant_ready = ($urandom_range(0, 3) != 0);
      ovf_clr     = ($urandom_range(0, 15) == 0);
      rst         = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
